// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch slice.
//   fetch_state_t : fetch sequencer states (FETCH, END, HALT)
//   fetch_entry_t : one buffered fetch result {pc, inst}
//   OPC_SYSTEM    : RISC-V SYSTEM major opcode (ecall/ebreak/csr*)
//   is_system()   : true when an instruction word carries OPC_SYSTEM
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    END   = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic is_system(input logic [XLEN-1:0] inst);
    return inst[6:0] == OPC_SYSTEM;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} entries.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_push, i_wdata  write entry at tail (caller guarantees room, or a same-cycle pop)
//   i_pop            drop head (caller guarantees o_valid)
//   i_flush          discard all entries; takes priority over push/pop
//   o_head           current head entry (all zeros after reset)
//   o_valid          FIFO not empty
//   o_count          number of stored entries
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fetch_entry_t  i_wdata,
  output fetch_entry_t  o_head,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // When full, a push writes the slot the pop is vacating; the head
      // was already consumed from the old contents this cycle.
      if (i_push) begin
        mem_q[wr_ptr_q] <= i_wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (i_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({i_push, i_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_valid = (count_q != '0);
  assign o_count = count_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, addresses the combinational
// instruction memory and buffers {pc, inst} into fetch_fifo for decode.
// Optional feature macro: HALT_ON_SYSTEM_EN -- when defined, pushing a
// SYSTEM-opcode word moves the sequencer to HALT (only reset leaves it).
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_fetch_en             fetch enable; low freezes fetching, FIFO still drains
//   o_mem_addr, i_mem_data word address out, instruction word back (same cycle)
//   i_redirect_valid/_pc   one-cycle redirect from execute (word index)
//   o_inst_valid, i_inst_ready, o_inst, o_inst_pc
//                          decode handshake: a transfer happens on a cycle
//                          where valid & ready are both high at the clock
//                          edge; while valid & !ready the head data is held
//                          stable, and valid never drops without a transfer
//                          except on redirect flush or reset
//   o_halted               fetch stopped (END/HALT) and FIFO empty
module inst_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter int          MEM_WORDS = 10,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_fetch_en,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  output logic            o_halted
);

  localparam int CW = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;
  localparam logic [XLEN-1:0] MEM_END  = XLEN'(MEM_WORDS);
  localparam logic [XLEN-1:0] MEM_LAST = XLEN'(MEM_WORDS - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;

  logic            fifo_valid;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;

  logic pop;
  logic push;
  logic redirect_take;
  logic enter_halt;

  // Redirects are dropped entirely in HALT: no flush, no PC change.
  assign redirect_take = i_redirect_valid && (state_q != HALT);

  assign pop  = fifo_valid && i_inst_ready;
  assign push = (state_q == FETCH) && i_fetch_en && !i_redirect_valid &&
                ((fifo_count < FULL_CNT) || pop);

`ifdef HALT_ON_SYSTEM_EN
  assign enter_halt = is_system(i_mem_data);
`else
  assign enter_halt = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else if (redirect_take) begin
      pc_q    <= i_redirect_pc;
      state_q <= (i_redirect_pc >= MEM_END) ? END : FETCH;
    end else if (push) begin
      pc_q <= pc_q + 1'b1;
      // HALT outranks END so a SYSTEM word in the last slot still locks out redirects.
      if (enter_halt)            state_q <= HALT;
      else if (pc_q == MEM_LAST) state_q <= END;
    end
  end

  assign push_entry.pc   = pc_q;
  assign push_entry.inst = i_mem_data;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_pop   (pop),
    .i_flush (redirect_take),
    .i_wdata (push_entry),
    .o_head  (fifo_head),
    .o_valid (fifo_valid),
    .o_count (fifo_count)
  );

  assign o_mem_addr   = pc_q;
  assign o_inst_valid = fifo_valid;
  assign o_inst       = fifo_head.inst;
  assign o_inst_pc    = fifo_head.pc;
  assign o_halted     = ((state_q == END) || (state_q == HALT)) && (fifo_count == '0);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a 10-word program image.
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        halted;

  int n_checks;
  int n_fail;

  logic [31:0] image [10];

  inst_fetch_ctrl #(
    .DEPTH     (2),
    .MEM_WORDS (10),
    .RESET_PC  (32'd0)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_fetch_en       (fetch_en),
    .o_mem_addr       (mem_addr),
    .i_mem_data       (mem_data),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_inst_valid     (inst_valid),
    .i_inst_ready     (inst_ready),
    .o_inst           (inst),
    .o_inst_pc        (inst_pc),
    .o_halted         (halted)
  );

  // Clock / combinational memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data = (mem_addr < 32'd10) ? image[mem_addr[3:0]] : 32'h0000_0000;

  // Driver tasks
  task automatic do_reset(input logic ready);
    rst            = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    inst_ready     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b0;
    fetch_en   = 1'b1;
    inst_ready = ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", inst_valid); end
    n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h exp 00000000", inst); end
    n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h exp 00000000", inst_pc); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b exp 0", halted); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h exp 00000000", mem_addr); end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b exp 1", i, inst_valid); end
      n_checks++; if (inst_pc !== 32'(i)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %0d exp %0d", i, inst_pc, i); end
      n_checks++; if (inst !== image[i]) begin n_fail++; $display("FAIL stream_inst[%0d]: got %h exp %h", i, inst, image[i]); end
      if (i == 8) begin
        n_checks++; if (inst !== 32'hFEB618E3) begin n_fail++; $display("FAIL stream_inst_pc8: got %h exp feb618e3", inst); end
      end
    end
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid: got %b exp 0", inst_valid); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL stream_end_halted: got %b exp 1", halted); end
    n_checks++; if (mem_addr !== 32'd10) begin n_fail++; $display("FAIL stream_end_addr: got %0d exp 10", mem_addr); end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b exp 1", c, inst_valid); end
      n_checks++; if (inst !== 32'h00A00593) begin n_fail++; $display("FAIL bp_hold_inst[%0d]: got %h exp 00a00593", c, inst); end
      n_checks++; if (inst_pc !== 32'd0) begin n_fail++; $display("FAIL bp_hold_pc[%0d]: got %0d exp 0", c, inst_pc); end
      if (c >= 2) begin
        n_checks++; if (mem_addr !== 32'd2) begin n_fail++; $display("FAIL bp_stall_addr[%0d]: got %0d exp 2", c, mem_addr); end
      end
    end
    inst_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(i)) begin
        n_fail++; $display("FAIL bp_resume[%0d]: got valid=%b pc=%0d exp valid=1 pc=%0d", i, inst_valid, inst_pc, i);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    for (int i = 0; i <= 8; i++) @(negedge clk);
    n_checks++; if (inst_pc !== 32'd8) begin n_fail++; $display("FAIL redir_pre_pc: got %0d exp 8", inst_pc); end
    // Stall one cycle so pc 9 gets buffered behind pc 8.
    inst_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (inst_pc !== 32'd8 || inst !== 32'hFEB618E3) begin
      n_fail++; $display("FAIL redir_hold: got pc=%0d inst=%h exp pc=8 inst=feb618e3", inst_pc, inst);
    end
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd4;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef HALT_ON_SYSTEM_EN
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd9) begin
      n_fail++; $display("FAIL redir_halt_head: got valid=%b pc=%0d exp valid=1 pc=9", inst_valid, inst_pc);
    end
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0 || halted !== 1'b1) begin
      n_fail++; $display("FAIL redir_halt_done: got valid=%b halted=%b exp valid=0 halted=1", inst_valid, halted);
    end
`else
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush_valid: got %b exp 0", inst_valid); end
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd4 || inst !== 32'h00E687B3) begin
      n_fail++; $display("FAIL redir_target: got valid=%b pc=%0d inst=%h exp valid=1 pc=4 inst=00e687b3", inst_valid, inst_pc, inst);
    end
`endif
  endtask

  task automatic test_end_redirect();
    do_reset(1'b1);
    for (int i = 0; i <= 10; i++) @(negedge clk);
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL endr_pre_halted: got %b exp 1", halted); end
    redirect_valid = 1'b1; redirect_pc = 32'd7;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL endr_gap_valid: got %b exp 0", inst_valid); end
`ifdef HALT_ON_SYSTEM_EN
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0 || halted !== 1'b1 || mem_addr !== 32'd10) begin
      n_fail++; $display("FAIL endr_halt_ignore: got valid=%b halted=%b addr=%0d exp 0/1/10", inst_valid, halted, mem_addr);
    end
`else
    for (int i = 7; i <= 9; i++) begin
      @(negedge clk);
      n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(i) || inst !== image[i]) begin
        n_fail++; $display("FAIL endr_replay[%0d]: got valid=%b pc=%0d inst=%h exp pc=%0d inst=%h", i, inst_valid, inst_pc, inst, i, image[i]);
      end
    end
    @(negedge clk);
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL endr_rehalted: got %b exp 1", halted); end
`endif
    redirect_valid = 1'b1; redirect_pc = 32'd12;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0 || halted !== 1'b1) begin
      n_fail++; $display("FAIL endr_out_of_image: got valid=%b halted=%b exp valid=0 halted=1", inst_valid, halted);
    end
`ifdef HALT_ON_SYSTEM_EN
    n_checks++; if (mem_addr !== 32'd10) begin n_fail++; $display("FAIL endr_addr: got %0d exp 10", mem_addr); end
`else
    n_checks++; if (mem_addr !== 32'd12) begin n_fail++; $display("FAIL endr_addr: got %0d exp 12", mem_addr); end
`endif
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd0 || mem_addr !== 32'd2) begin
      n_fail++; $display("FAIL ares_pre: got valid=%b pc=%0d addr=%0d exp 1/0/2", inst_valid, inst_pc, mem_addr);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL ares_valid_drop: got %b exp 0", inst_valid); end
    n_checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin
      n_fail++; $display("FAIL ares_head_clear: got inst=%h pc=%h exp 0/0", inst, inst_pc);
    end
    n_checks++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL ares_addr: got %0d exp 0", mem_addr); end
    @(negedge clk);
    rst = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd0 || inst !== 32'h00A00593) begin
      n_fail++; $display("FAIL ares_restart: got valid=%b pc=%0d inst=%h exp 1/0/00a00593", inst_valid, inst_pc, inst);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    image[0] = 32'h00A00593;
    image[1] = 32'h00000613;
    image[2] = 32'h00100693;
    image[3] = 32'h00000713;
    image[4] = 32'h00E687B3;
    image[5] = 32'h00F70733;
    image[6] = 32'h00068693;
    image[7] = 32'h00160613;
    image[8] = 32'hFEB618E3;
    image[9] = 32'h00070073;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_end_redirect();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Fetch sequencer in front of the combinational, word-indexed instruction memory. It owns the fetch PC, drives the memory address, and captures each returned word with its PC into a small FIFO. It presents instructions to decode over a valid/ready handshake, honours backpressure and branch/jump redirects, and stops cleanly at the end of the program image.

Parameters:
DEPTH, 2, FIFO entries (power of 2, >=2)
MEM_WORDS, 10, number of valid instruction words; addresses >= MEM_WORDS are outside the image
RESET_PC, 0, fetch PC loaded at reset (word index)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_fetch_en  in  1  global fetch enable; low freezes fetching, buffered entries still drain
o_mem_addr  out  32  word address to instruction memory (= fetch_pc)
i_mem_data  in  32  instruction word returned combinationally for o_mem_addr
i_redirect_valid  in  1  one-cycle redirect request from execute
i_redirect_pc  in  32  redirect target, word index
o_inst_valid  out  1  FIFO head valid
i_inst_ready  in  1  decode accepts head
o_inst  out  32  head instruction
o_inst_pc  out  32  head PC (word index)
o_halted  out  1  fetch stopped (END/HALT) and FIFO empty

Behaviour:
- Reset (async): fetch_pc=RESET_PC, FIFO count=0, state=FETCH. o_inst_valid=0, o_inst=0, o_inst_pc=0, o_halted=0.
- States: FETCH, END, HALT.
- pop = o_inst_valid & i_inst_ready. push = state==FETCH & i_fetch_en & !i_redirect_valid & (count<DEPTH | pop).
- push writes {fetch_pc, i_mem_data} at tail; fetch_pc += 1. Fetch-to-valid latency: 1 cycle. A full FIFO with a same-cycle pop still pushes, so throughput is 1/cycle.
- FETCH->END when push occurs with fetch_pc == MEM_WORDS-1. FETCH->END on a redirect to a target >= MEM_WORDS. No push in END.
- Redirect (highest priority): any pop that cycle completes, then all entries are flushed (count=0). fetch_pc=i_redirect_pc. Nothing is pushed that cycle. The first new entry is valid 2 cycles after the redirect edge.
  - From END: target < MEM_WORDS returns to FETCH; otherwise stays END.
  - Ignored in HALT.
- Simultaneous push+pop: count unchanged, pointers both advance. Pointers wrap modulo DEPTH.
- o_inst/o_inst_pc hold the head value. They are stable while o_inst_valid & !i_inst_ready, i.e. must not change until accepted.
- o_halted = (state==END | state==HALT) & count==0. It is combinational from state/count.
- Reset mid-operation: discards FIFO and state immediately; no partial pops visible.
- Arithmetic: fetch_pc is 32-bit and wraps at 2^32. The MEM_WORDS compare is unsigned.

Optional Feature:
HALT_ON_SYSTEM_EN
- Defined: a pushed word with opcode[6:0]==7'b1110011 is still pushed, then state goes to HALT. Fetching stops and redirects are ignored. o_halted rises once the FIFO drains. Only reset exits HALT.
- Undefined: SYSTEM opcodes are fetched like any other instruction; the HALT state is not built.

Decomposition:
- Shared package cpu_pkg:
  - typedef fetch_state_t {FETCH, END, HALT}
  - localparam OPC_SYSTEM=7'b1110011
  - localparam XLEN=32
  - typedef struct fetch_entry_t {pc, inst}
- One sub-module: fetch_fifo (parameterised DEPTH; push/pop/flush, count, head outputs, async active-high reset).
- The controller holds the PC, state machine and push/pop logic.

Test Plan:
- Streaming, i_inst_ready=1, 10-word image (0x00A00593..0x00070073): o_inst_pc 0..9 on consecutive cycles; first valid 1 cycle after reset release; o_inst at pc 8 = 0xFEB618E3. After pc 9, o_halted=1 and o_mem_addr holds 10.
- Backpressure: i_inst_ready=0 for 5 cycles after reset. FIFO fills to 2 (pc 0,1) and o_mem_addr stalls at 2. o_inst stays 0x00A00593. Releasing ready resumes 0,1,2,... with no gap or duplicate.
- Redirect while pc 8 (0xFEB618E3) is accepted, i_redirect_pc=4. Pop of pc 8 completes and any buffered pc 9 is flushed. The next delivered entry is pc 4 = 0x00E687B3, 2 cycles later.
- Redirect from END: after draining to pc 9, redirect to 7 gives pc 7,8,9 (0x00160613, 0xFEB618E3, 0x00070073). Redirect to 12 leaves o_halted=1.
- HALT_ON_SYSTEM_EN defined: pc 9 (0x00070073) is delivered, then o_halted=1. A later redirect to 0 produces no new valid. Without the macro, behaviour matches END.
- Async reset asserted mid-stream with 2 entries buffered: o_inst_valid drops immediately, without waiting for a clock edge. After release, fetch restarts at pc 0.
